// File: rtl/dpram_pkg.sv
// Shared memory constants so the CPU side and the dual-port RAM agree on geometry,
// plus a small helper used to detect same-address accesses from both ports.
package dpram_pkg;

    localparam int MEM_DATA_WIDTH = 16;
    localparam int MEM_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } access_e;

    // True when both ports target the same word in this cycle.
    function automatic logic same_word(
        input logic [MEM_ADDR_WIDTH-1:0] a,
        input logic [MEM_ADDR_WIDTH-1:0] b
    );
        return (a == b);
    endfunction

endpackage

// File: rtl/dpram.sv
// True dual-port RAM: write-first per port, read-first across ports, port A wins
// simultaneous writes to one word. Outputs are registered; reset clears only the outputs.
module dpram
    import dpram_pkg::*;
#(
    parameter int    DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int    ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_A,
    input  logic                  en_B,
    input  logic [ADDR_WIDTH-1:0] addr_A,
    input  logic [ADDR_WIDTH-1:0] addr_B,
    input  logic [DATA_WIDTH-1:0] data_A,
    input  logic [DATA_WIDTH-1:0] data_B,
    output logic [DATA_WIDTH-1:0] out_A,
    output logic [DATA_WIDTH-1:0] out_B
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ram [DEPTH-1:0];

    logic                  collide_s;
    logic                  wr_a_s;
    logic                  wr_b_s;
    logic [DATA_WIDTH-1:0] next_a_s;
    logic [DATA_WIDTH-1:0] next_b_s;

    // Decode writes and next read data; B's write is dropped when A hits the same word.
    always_comb begin
        collide_s = 1'b0;
        wr_a_s    = 1'b0;
        wr_b_s    = 1'b0;
        next_a_s  = '0;
        next_b_s  = '0;

        if (en_A && en_B) begin
            collide_s = (addr_A == addr_B);
        end else begin
            collide_s = 1'b0;
        end

        wr_a_s = en_A;
        wr_b_s = en_B && !collide_s;

        if (en_A) begin
            next_a_s = data_A;
        end else begin
            next_a_s = ram[addr_A];
        end

        if (en_B) begin
            if (collide_s) begin
                next_b_s = data_A;
            end else begin
                next_b_s = data_B;
            end
        end else begin
            next_b_s = ram[addr_B];
        end
    end

    // Storage and registered read ports; reset suppresses writes but keeps contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_A <= '0;
            out_B <= '0;
        end else begin
            if (wr_b_s) begin
                ram[addr_B] <= data_B;
            end
            if (wr_a_s) begin
                ram[addr_A] <= data_A;
            end
            out_A <= next_a_s;
            out_B <= next_b_s;
        end
    end

endmodule

// File: tb/tb_dpram.sv
// Directed vector table plus hold check and a scoreboard-backed random soak for dpram.
module tb_dpram;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          rst_n;
    logic          en_A, en_B;
    logic [AW-1:0] addr_A, addr_B;
    logic [DW-1:0] data_A, data_B;
    logic [DW-1:0] out_A, out_B;

    int checks;
    int errors;

    dpram uut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_A   (en_A),
        .en_B   (en_B),
        .addr_A (addr_A),
        .addr_B (addr_B),
        .data_A (data_A),
        .data_B (data_B),
        .out_A  (out_A),
        .out_B  (out_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          en_a;
        logic          en_b;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [DW-1:0] data_a;
        logic [DW-1:0] data_b;
        logic          chk_a;
        logic          chk_b;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        string         name;
    } vec_t;

    vec_t vecs[12];

    logic [DW-1:0] model [DEPTH];
    logic          valid [DEPTH];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ea, input logic eb,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                         input logic [DW-1:0] da, input logic [DW-1:0] db);
        rst_n  = r;
        en_A   = ea;
        en_B   = eb;
        addr_A = aa;
        addr_B = ab;
        data_A = da;
        data_B = db;
    endtask

    initial begin
        logic [DW-1:0] hold_a, hold_b;
        logic [AW-1:0] ra, rb;
        logic [DW-1:0] rda, rdb;
        logic          rea, reb;
        logic [DW-1:0] ea_exp, eb_exp;
        logic [DW-1:0] ram_word;

        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) valid[i] = 1'b0;

        //          rst  enA  enB  addrA   addrB   dataA      dataB      chkA chkB expA       expB       name
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 10'd5,   10'd5,   16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h0000, "preload_5"};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 10'd5,   10'd6,   16'hDEAD, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'h0000, "reset_clear"};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'd5,   10'd5,   16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h1234, "ram_survives_reset"};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 10'd3,   10'd900, 16'hBEEF, 16'h0F0F, 1'b1, 1'b1, 16'hBEEF, 16'h0F0F, "write_first"};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 10'd17,  10'd3,   16'hA5A5, 16'h0000, 1'b1, 1'b1, 16'hA5A5, 16'hBEEF, "write17_read3"};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'd900, 10'd17,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0F0F, 16'hA5A5, "cross_read"};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 10'd42,  10'd42,  16'h1111, 16'h2222, 1'b1, 1'b1, 16'h1111, 16'h1111, "collision_a_wins"};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 10'd42,  10'd42,  16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1111, 16'h1111, "collision_readback"};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 10'd8,   10'd900, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0001, 16'h0F0F, "init_addr8"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 10'd8,   10'd8,   16'h7777, 16'h0000, 1'b1, 1'b1, 16'h7777, 16'h0001, "a_wr_b_rd_old"};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 10'd8,   10'd8,   16'h0000, 16'h3333, 1'b1, 1'b1, 16'h7777, 16'h3333, "b_wr_a_rd_old"};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 10'd8,   10'd8,   16'h0000, 16'h0000, 1'b1, 1'b1, 16'h3333, 16'h3333, "final_addr8"};

        drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 16'h0000, 16'h0000);
        @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].en_a, vecs[i].en_b, vecs[i].addr_a,
                  vecs[i].addr_b, vecs[i].data_a, vecs[i].data_b);
            @(posedge clk);
            #1;
            if (vecs[i].chk_a) check({vecs[i].name, "_A"}, out_A, vecs[i].exp_a);
            if (vecs[i].chk_b) check({vecs[i].name, "_B"}, out_B, vecs[i].exp_b);
        end

        // Outputs must hold between edges while inputs move.
        hold_a = out_A;
        hold_b = out_B;
        drive(1'b1, 1'b1, 1'b1, 10'd100, 10'd101, 16'hCAFE, 16'hF00D);
        #2;
        check("hold_A", out_A, hold_a);
        check("hold_B", out_B, hold_b);
        drive(1'b1, 1'b0, 1'b0, 10'd8, 10'd8, 16'h0000, 16'h0000);

        // Seed the scoreboard with the directed writes.
        model[5] = 16'h1234;  valid[5] = 1'b1;
        model[3] = 16'hBEEF;  valid[3] = 1'b1;
        model[900] = 16'h0F0F; valid[900] = 1'b1;
        model[17] = 16'hA5A5; valid[17] = 1'b1;
        model[42] = 16'h1111; valid[42] = 1'b1;
        model[8] = 16'h3333;  valid[8] = 1'b1;

        for (int c = 0; c < 160; c++) begin
            ra  = AW'($urandom_range(0, DEPTH - 1));
            rb  = ra ^ AW'($urandom_range(1, DEPTH - 1));
            rda = DW'($urandom);
            rdb = DW'($urandom);
            rea = 1'($urandom_range(0, 1));
            reb = 1'($urandom_range(0, 1));
            @(negedge clk);
            drive(1'b1, rea, reb, ra, rb, rda, rdb);
            ea_exp = rea ? rda : model[ra];
            eb_exp = reb ? rdb : model[rb];
            @(posedge clk);
            #1;
            if (rea || valid[ra]) check("soak_A", out_A, ea_exp);
            if (reb || valid[rb]) check("soak_B", out_B, eb_exp);
            if (rea) begin model[ra] = rda; valid[ra] = 1'b1; end
            if (reb) begin model[rb] = rdb; valid[rb] = 1'b1; end
        end

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                ram_word = uut.ram[i];
                check($sformatf("ram_%0d", i), ram_word, model[i]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram.md
DPRAM -- requirements
Module: dpram

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; depth = 2**ADDR_WIDTH (1024 words).
REQ-003 Parameter INIT_FILE, default "" (empty): optional hex image loaded at elaboration; empty means contents start undefined.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 en_A  input  1: port A write enable.
REQ-007 en_B  input  1: port B write enable.
REQ-008 addr_A  input  ADDR_WIDTH: port A address.
REQ-009 addr_B  input  ADDR_WIDTH: port B address.
REQ-010 data_A  input  DATA_WIDTH: port A write data.
REQ-011 data_B  input  DATA_WIDTH: port B write data.
REQ-012 out_A  output  DATA_WIDTH: port A registered read data.
REQ-013 out_B  output  DATA_WIDTH: port B registered read data.
REQ-014 Storage array SHALL be an internal reg array named ram [depth-1:0], reachable hierarchically (uut.ram) by benches; no port exposes it.

Function
REQ-015 Both ports SHALL be fully independent read/write ports on one shared array, operating in the same clk cycle.
REQ-016 en_X=1 at a rising edge SHALL write data_X into ram[addr_X].
REQ-017 Read-during-write on the same port SHALL be write-first: out_X SHALL equal data_X after that edge.
REQ-018 en_X=0 at a rising edge SHALL load out_X with ram[addr_X] (contents before any same-edge write from the other port); read latency 1 cycle.
REQ-019 out_A/out_B SHALL change only on rising clk edges; they SHALL hold between edges regardless of input changes.
REQ-020 Collision, both enables high, addr_A==addr_B: port A SHALL win; ram[addr] = data_A; out_A = out_B = data_A.
REQ-021 Collision, one port writing, other reading same address: reader SHALL get the old contents (read-first across ports); writer gets its own data.
REQ-022 Addresses SHALL be used at full ADDR_WIDTH; no out-of-range condition exists; no wrap logic required.
REQ-023 No combinational path from any input to out_A/out_B.

Reset
REQ-024 rst_n=0 at a rising edge SHALL clear out_A and out_B to 0; writes on that edge SHALL be suppressed.
REQ-025 Reset SHALL NOT clear ram contents (block-RAM inferable); contents persist across reset.
REQ-026 First edge with rst_n=1 SHALL operate normally per REQ-016..021.

Structure
REQ-027 DATA_WIDTH/ADDR_WIDTH defaults SHALL come from the shared project package (memory constants) so CPU and memory agree.
REQ-028 One module, no sub-modules; memory, both port processes in one block inferable as true dual-port BRAM.

Verification
REQ-029 Reset: rst_n=0 one edge, then release -> out_A=out_B=0x0000; a prior ram[5]=0x1234 still reads 0x1234 afterwards.
REQ-030 Write-first: en_A=1, addr_A=3, data_A=0xBEEF; en_B=1, addr_B=900, data_B=0x0F0F, one edge -> out_A=0xBEEF, out_B=0x0F0F.
REQ-031 Cross-port read: write ram[17]=0xA5A5 via A; next edge en_B=0, addr_B=17 -> out_B=0xA5A5 after one edge.
REQ-032 Collision: both enables, addr 42, data_A=0x1111, data_B=0x2222 -> out_A=out_B=0x1111; later read ram[42]=0x1111.
REQ-033 Read/write same address: A writes 0x7777 to addr 8 (old 0x0001), B reads addr 8 same edge -> out_B=0x0001, out_A=0x7777.
REQ-034 Random soak: 160 cycles of random data/addresses on both ports with distinct addresses -> each out_X equals its data_X after every write edge; scoreboard matches ram.
